// File: rtl/fan_pwm_driver.sv
// fan_pwm_driver
//
// Fixed-frequency PWM motor driver for the fan. The 3-bit speed code from the
// fan control FSM selects a target duty. The applied duty moves toward that
// target in small steps at a controlled rate, and only ever changes on a PWM
// period boundary, so a pulse is never cut short.
//
// Parameters
//   PWM_PERIOD  clocks per PWM period (5..255)
//   RAMP_DIV    PWM periods between ramp steps (>= 1)
//   DUTY_STEP   duty change per ramp step, in clocks (>= 1)
//
// Ports
//   i_clk          system clock
//   i_reset_n      synchronous active-low reset
//   i_enable       1 = run, 0 = stop the motor on the next clock
//   i_fanState     speed code: 0=OFF, 1..4 = 20%..80%, 5..7 treated as OFF
//   o_pwm          registered motor drive
//   o_periodStart  registered one-cycle pulse on the first cycle of each period
//   o_duty         duty currently applied, in clocks
//   o_busy         1 while the duty is ramping up or down

module fan_pwm_driver #(
  parameter int unsigned PWM_PERIOD = 100,
  parameter int unsigned RAMP_DIV   = 4,
  parameter int unsigned DUTY_STEP  = 5
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic [2:0] i_fanState,
  output logic       o_pwm,
  output logic       o_periodStart,
  output logic [7:0] o_duty,
  output logic       o_busy
);

  localparam int unsigned RcntW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [7:0]       PeriodLast = 8'(PWM_PERIOD - 1);
  localparam logic [RcntW-1:0] RampLast   = RcntW'(RAMP_DIV - 1);
  localparam logic [8:0]       Step9      = 9'(DUTY_STEP);

  // Target duty per speed code, floor(code * PWM_PERIOD / 5).
  localparam logic [7:0] Tgt1 = 8'((1 * PWM_PERIOD) / 5);
  localparam logic [7:0] Tgt2 = 8'((2 * PWM_PERIOD) / 5);
  localparam logic [7:0] Tgt3 = 8'((3 * PWM_PERIOD) / 5);
  localparam logic [7:0] Tgt4 = 8'((4 * PWM_PERIOD) / 5);

  typedef enum logic [1:0] {
    StOff,
    StUp,
    StDown,
    StHold
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_next;
  logic [RcntW-1:0] r_rcnt;
  logic [RcntW-1:0] w_rcnt_next;
  logic [7:0]       r_target;
  logic [7:0]       w_target_next;
  logic [7:0]       r_duty;
  logic [7:0]       w_duty_next;
  logic             r_pwm;
  logic             r_period_start;

  logic             w_boundary;
  logic             w_ramping;
  logic             w_ramp_next;
  logic [8:0]       w_up_sum;
  logic [8:0]       w_dn_diff;
  logic [7:0]       w_up_duty;
  logic [7:0]       w_dn_duty;
  logic [7:0]       w_step_duty;

  // ---------------------------------------------------------------------------
  // Period counter and target decode
  // ---------------------------------------------------------------------------

  assign w_boundary = (r_cnt == PeriodLast);
  assign w_cnt_next = w_boundary ? 8'd0 : r_cnt + 8'd1;

  always_comb begin
    w_target_next = 8'd0;
    case (i_fanState)
      3'd1:    w_target_next = Tgt1;
      3'd2:    w_target_next = Tgt2;
      3'd3:    w_target_next = Tgt3;
      3'd4:    w_target_next = Tgt4;
      default: w_target_next = 8'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Ramp step arithmetic, 9 bits wide so neither direction can wrap
  // ---------------------------------------------------------------------------

  assign w_up_sum  = {1'b0, r_duty} + Step9;
  assign w_dn_diff = {1'b0, r_duty} - Step9;

  assign w_up_duty = (w_up_sum > {1'b0, r_target}) ? r_target : w_up_sum[7:0];
  // A borrow in bit 8 means the step would go below zero, which is below any target.
  assign w_dn_duty = (w_dn_diff[8] || (w_dn_diff[7:0] < r_target)) ? r_target
                                                                    : w_dn_diff[7:0];

  // Direction comes from the registered duty/target rather than the state
  // register, so a target change that coincides with a step can never jump
  // the duty across the new target.
  always_comb begin
    w_step_duty = r_duty;
    if (r_duty < r_target) begin
      w_step_duty = w_up_duty;
    end else if (r_duty > r_target) begin
      w_step_duty = w_dn_duty;
    end
  end

  // ---------------------------------------------------------------------------
  // Duty register and ramp prescaler next state
  // ---------------------------------------------------------------------------

  assign w_ramping   = (r_state == StUp) || (r_state == StDown);
  assign w_ramp_next = (w_state_next == StUp) || (w_state_next == StDown);

  always_comb begin
    w_duty_next = r_duty;
    w_rcnt_next = r_rcnt;
    if (!i_enable) begin
      w_duty_next = 8'd0;
      w_rcnt_next = '0;
    end else begin
      if (w_ramping && w_boundary) begin
        if (r_rcnt == RampLast) begin
          w_rcnt_next = '0;
          w_duty_next = w_step_duty;
        end else begin
          w_rcnt_next = r_rcnt + 1'b1;
        end
      end
      // Prescaler only counts during a ramp; reversal keeps the count.
      if (!w_ramping || !w_ramp_next) begin
        w_rcnt_next = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt          <= 8'd0;
      r_rcnt         <= '0;
      r_target       <= 8'd0;
      r_duty         <= 8'd0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_next;
      r_rcnt         <= w_rcnt_next;
      r_target       <= w_target_next;
      r_duty         <= w_duty_next;
      // Outputs trail the counter by one cycle; the high phase covers
      // counter values 0..duty-1, i.e. exactly duty cycles.
      r_pwm          <= i_enable && (r_cnt < r_duty);
      r_period_start <= (r_cnt == 8'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Ramp state machine
  // ---------------------------------------------------------------------------

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= StOff;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = StOff;
    if (!i_enable) begin
      w_state_next = StOff;
    end else if (r_duty < r_target) begin
      w_state_next = StUp;
    end else if (r_duty > r_target) begin
      w_state_next = StDown;
    end else if (r_target == 8'd0) begin
      w_state_next = StOff;
    end else begin
      w_state_next = StHold;
    end
  end

  always_comb begin
    o_busy = 1'b0;
    case (r_state)
      StUp, StDown: o_busy = 1'b1;
      default:      o_busy = 1'b0;
    endcase
  end

  assign o_pwm         = r_pwm;
  assign o_periodStart = r_period_start;
  assign o_duty        = r_duty;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Testbench for fan_pwm_driver: one instance with default parameters and one
// with a short period (7), step 3 and ramp divider 1. Each instance is
// shadowed by a behavioural model advanced on every rising edge.

module tb_fan_pwm_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_en, a_pwm, a_ps, a_busy;
  logic [2:0] a_fs;
  logic [7:0] a_duty;
  logic       b_rst_n, b_en, b_pwm, b_ps, b_busy;
  logic [2:0] b_fs;
  logic [7:0] b_duty;

  fan_pwm_driver u_dut_a (
    .i_clk        (clk),
    .i_reset_n    (a_rst_n),
    .i_enable     (a_en),
    .i_fanState   (a_fs),
    .o_pwm        (a_pwm),
    .o_periodStart(a_ps),
    .o_duty       (a_duty),
    .o_busy       (a_busy)
  );

  fan_pwm_driver #(
    .PWM_PERIOD(7),
    .RAMP_DIV  (1),
    .DUTY_STEP (3)
  ) u_dut_b (
    .i_clk        (clk),
    .i_reset_n    (b_rst_n),
    .i_enable     (b_en),
    .i_fanState   (b_fs),
    .o_pwm        (b_pwm),
    .o_periodStart(b_ps),
    .o_duty       (b_duty),
    .o_busy       (b_busy)
  );

  // Behavioural model: ramp state is classified straight from duty vs target.
  localparam int MOff = 0, MUp = 1, MDown = 2, MHold = 3;

  typedef struct packed {
    int cnt;
    int rcnt;
    int target;
    int duty;
    int st;
    bit pwm;
    bit ps;
  } mdl_t;

  function automatic int mdl_class(int duty, int target);
    if (duty < target) return MUp;
    else if (duty > target) return MDown;
    else if (target == 0) return MOff;
    else return MHold;
  endfunction

  function automatic mdl_t mdl_next(mdl_t s, int p, int stp, int rd, bit rst_n, bit en,
                                    int code);
    mdl_t n;
    bit   ramping;
    int   cls;
    n = s;
    if (!rst_n) begin
      n = '0;
      return n;
    end
    n.ps     = (s.cnt == 0);
    n.pwm    = en && (s.cnt < s.duty);
    n.cnt    = (s.cnt + 1) % p;
    n.target = (code <= 4) ? (code * p) / 5 : 0;
    if (!en) begin
      n.duty = 0;
      n.rcnt = 0;
      n.st   = MOff;
      return n;
    end
    cls     = mdl_class(s.duty, s.target);
    ramping = (s.st == MUp) || (s.st == MDown);
    if (ramping && s.cnt == p - 1) begin
      if (s.rcnt == rd - 1) begin
        n.rcnt = 0;
        if (s.duty < s.target)
          n.duty = (s.duty + stp > s.target) ? s.target : s.duty + stp;
        else if (s.duty > s.target)
          n.duty = (s.duty - stp < s.target) ? s.target : s.duty - stp;
      end else begin
        n.rcnt = s.rcnt + 1;
      end
    end
    n.st = cls;
    if (!ramping || !(cls == MUp || cls == MDown)) n.rcnt = 0;
    return n;
  endfunction

  mdl_t ma = '0;
  mdl_t mb = '0;

  always @(posedge clk) begin
    ma <= mdl_next(ma, 100, 5, 4, a_rst_n, a_en, int'(a_fs));
    mb <= mdl_next(mb, 7, 3, 1, b_rst_n, b_en, int'(b_fs));
  end

  logic [10:0] a_got, a_exp, b_got, b_exp;
  assign a_got = {a_pwm, a_ps, a_duty, a_busy};
  assign a_exp = {ma.pwm, ma.ps, ma.duty[7:0], (ma.st == MUp || ma.st == MDown)};
  assign b_got = {b_pwm, b_ps, b_duty, b_busy};
  assign b_exp = {mb.pwm, mb.ps, mb.duty[7:0], (mb.st == MUp || mb.st == MDown)};

  int n_cmp = 0;
  int n_err = 0;

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    a_rst_n = 1'b0; a_en = 1'b1; a_fs = 3'd4;
    b_rst_n = 1'b0; b_en = 1'b1; b_fs = 3'd0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (a_got !== 11'd0) begin
        n_err++; $display("FAIL reset_outputs_a dut=%h want=000 @%0t", a_got, $time);
      end
      n_cmp++;
      if (b_got !== 11'd0) begin
        n_err++; $display("FAIL reset_outputs_b dut=%h want=000 @%0t", b_got, $time);
      end
    end
    a_rst_n = 1'b1; b_rst_n = 1'b1; a_fs = 3'd0;
    @(negedge clk);
    n_cmp++;
    if (a_ps !== 1'b1 || a_duty !== 8'd0) begin
      n_err++; $display("FAIL first_period_start ps=%b duty=%0d want ps=1 duty=0", a_ps, a_duty);
    end
    n_cmp++;
    if (b_ps !== 1'b1) begin
      n_err++; $display("FAIL first_period_start_b ps=%b want 1", b_ps);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (a_got !== a_exp) begin
        n_err++; $display("FAIL post_reset dut=%h model=%h @%0t", a_got, a_exp, $time);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ramp_up();
    int k, last, nchg, hi;
    logic [7:0] prev;
    a_fs = 3'd2;
    @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0) begin
      n_err++; $display("FAIL busy_at_target_load busy=%b want 0", a_busy);
    end
    @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b1) begin
      n_err++; $display("FAIL busy_after_target_load busy=%b want 1", a_busy);
    end
    prev = a_duty; k = 0; last = 0; nchg = 0;
    while (!(a_duty == 8'd40 && a_busy == 1'b0) && k < 16000) begin
      @(negedge clk); k++;
      n_cmp++;
      if (a_got !== a_exp) begin
        n_err++; $display("FAIL ramp_up_model dut=%h model=%h @%0t", a_got, a_exp, $time);
      end
      if (a_duty !== prev) begin
        n_cmp++;
        if (a_duty !== prev + 8'd5) begin
          n_err++; $display("FAIL ramp_up_step duty=%0d want %0d", a_duty, prev + 8'd5);
        end
        if (nchg > 0) begin
          n_cmp++;
          if (k - last != 400) begin
            n_err++; $display("FAIL ramp_up_interval cycles=%0d want 400", k - last);
          end
        end
        nchg++; last = k; prev = a_duty;
      end
    end
    n_cmp++;
    if (k >= 16000 || nchg != 8 || k - last != 1) begin
      n_err++;
      $display("FAIL ramp_up_end steps=%0d want 8, busy_lag=%0d want 1, k=%0d", nchg, k - last,
               k);
    end
    k = 0;
    while (a_ps !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    hi = int'(a_pwm);
    repeat (99) begin @(negedge clk); hi += int'(a_pwm); end
    n_cmp++;
    if (hi != 40) begin
      n_err++; $display("FAIL hold40_pwm_high high=%0d want 40", hi);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ramp_down();
    int k, nchg, mn;
    logic [7:0] prev;
    a_fs = 3'd4; k = 0;
    while (!(a_duty == 8'd80 && a_busy == 1'b0) && k < 5000) begin
      @(negedge clk); k++;
      n_cmp++;
      if (a_got !== a_exp) begin
        n_err++; $display("FAIL up80_model dut=%h model=%h @%0t", a_got, a_exp, $time);
      end
    end
    n_cmp++;
    if (k >= 5000) begin n_err++; $display("FAIL up80_timeout duty=%0d want 80", a_duty); end
    a_fs = 3'd1; k = 0; nchg = 0; prev = a_duty; mn = 255;
    while (!(a_duty == 8'd20 && a_busy == 1'b0) && k < 6000) begin
      @(negedge clk); k++;
      n_cmp++;
      if (a_got !== a_exp) begin
        n_err++; $display("FAIL down20_model dut=%h model=%h @%0t", a_got, a_exp, $time);
      end
      if (a_duty !== prev) begin
        n_cmp++;
        if (a_duty !== prev - 8'd5) begin
          n_err++; $display("FAIL down20_step duty=%0d want %0d", a_duty, prev - 8'd5);
        end
        nchg++; prev = a_duty;
      end
      if (int'(a_duty) < mn) mn = int'(a_duty);
    end
    n_cmp++;
    if (k >= 6000 || nchg != 12 || mn != 20) begin
      n_err++; $display("FAIL down20_end steps=%0d want 12, min=%0d want 20", nchg, mn);
    end
    a_fs = 3'd4; k = 0;
    while (!(a_duty == 8'd80 && a_busy == 1'b0) && k < 6000) begin
      @(negedge clk); k++;
      n_cmp++;
      if (a_got !== a_exp) begin
        n_err++; $display("FAIL reup80_model dut=%h model=%h @%0t", a_got, a_exp, $time);
      end
    end
    a_fs = 3'd1; k = 0;
    while (a_duty != 8'd50 && k < 3000) begin
      @(negedge clk); k++;
      n_cmp++;
      if (a_got !== a_exp) begin
        n_err++; $display("FAIL down50_model dut=%h model=%h @%0t", a_got, a_exp, $time);
      end
    end
    n_cmp++;
    if (k >= 3000) begin n_err++; $display("FAIL down50_timeout duty=%0d want 50", a_duty); end
    a_fs = 3'd4; k = 0; mn = 255;
    while (!(a_duty == 8'd80 && a_busy == 1'b0) && k < 3000) begin
      @(negedge clk); k++;
      n_cmp++;
      if (a_got !== a_exp) begin
        n_err++; $display("FAIL reverse_model dut=%h model=%h @%0t", a_got, a_exp, $time);
      end
      if (int'(a_duty) < mn) mn = int'(a_duty);
    end
    n_cmp++;
    if (k >= 3000 || mn != 50 || a_duty !== 8'd80) begin
      n_err++; $display("FAIL reverse_end duty=%0d want 80, min=%0d want 50", a_duty, mn);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_invalid_codes();
    int k;
    logic [7:0] prev;
    a_fs = 3'd3; k = 0;
    while (!(a_duty == 8'd60 && a_busy == 1'b0) && k < 3000) begin
      @(negedge clk); k++;
      n_cmp++;
      if (a_got !== a_exp) begin
        n_err++; $display("FAIL hold60_model dut=%h model=%h @%0t", a_got, a_exp, $time);
      end
    end
    a_fs = 3'd5; k = 0; prev = a_duty;
    while (!(a_duty == 8'd0 && a_busy == 1'b0) && k < 6000) begin
      @(negedge clk); k++;
      if (k % 500 == 0) a_fs = 3'($urandom_range(5, 7));
      n_cmp++;
      if (a_got !== a_exp || a_duty > prev) begin
        n_err++;
        $display("FAIL invalid_code_ramp dut=%h model=%h prev_duty=%0d @%0t", a_got, a_exp,
                 prev, $time);
      end
      prev = a_duty;
    end
    n_cmp++;
    if (k >= 6000) begin n_err++; $display("FAIL invalid_code_timeout duty=%0d want 0", a_duty); end
    repeat (200) begin
      @(negedge clk);
      n_cmp++;
      if (a_pwm !== 1'b0 || a_busy !== 1'b0 || a_duty !== 8'd0) begin
        n_err++;
        $display("FAIL invalid_code_off pwm=%b busy=%b duty=%0d want 0/0/0", a_pwm, a_busy,
                 a_duty);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_enable();
    int k;
    logic [7:0] first;
    a_fs = 3'd3; k = 0;
    while (!(a_pwm == 1'b1 && a_duty >= 8'd10) && k < 3000) begin
      @(negedge clk); k++;
      n_cmp++;
      if (a_got !== a_exp) begin
        n_err++; $display("FAIL en_pre_model dut=%h model=%h @%0t", a_got, a_exp, $time);
      end
    end
    a_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_pwm !== 1'b0 || a_duty !== 8'd0 || a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL disable_stop pwm=%b duty=%0d busy=%b want 0/0/0 (wait=%0d)", a_pwm, a_duty,
               a_busy, k);
    end
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) a_fs = 3'($urandom_range(0, 7));
      @(negedge clk);
      n_cmp++;
      if (a_got !== a_exp || a_duty !== 8'd0) begin
        n_err++; $display("FAIL disabled_model dut=%h model=%h @%0t", a_got, a_exp, $time);
      end
    end
    a_fs = 3'd3; a_en = 1'b1; k = 0; first = 8'd0;
    while (!(a_duty == 8'd60 && a_busy == 1'b0) && k < 6000) begin
      @(negedge clk); k++;
      if (first == 8'd0) first = a_duty;
      n_cmp++;
      if (a_got !== a_exp) begin
        n_err++; $display("FAIL reenable_model dut=%h model=%h @%0t", a_got, a_exp, $time);
      end
    end
    n_cmp++;
    if (k >= 6000 || first !== 8'd5) begin
      n_err++; $display("FAIL reenable_restart first_duty=%0d want 5, k=%0d", first, k);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    for (int seg = 0; seg < 8; seg++) begin
      a_fs = 3'($urandom_range(0, 7));
      a_en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < int'($urandom_range(20, 1500)); i++) begin
        @(negedge clk);
        n_cmp++;
        if (a_got !== a_exp) begin
          n_err++; $display("FAIL random_model dut=%h model=%h @%0t", a_got, a_exp, $time);
        end
      end
    end
    a_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_short_period();
    int k, nchg, hi, last_ps;
    int chg_val[4];
    int chg_cyc[4];
    logic [7:0] prev;
    b_fs = 3'd4; nchg = 0; last_ps = -1; prev = b_duty;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      n_cmp++;
      if (b_got !== b_exp) begin
        n_err++; $display("FAIL short_model dut=%h model=%h @%0t", b_got, b_exp, $time);
      end
      if (b_duty !== prev && nchg < 4) begin
        chg_val[nchg] = int'(b_duty); chg_cyc[nchg] = c; nchg++; prev = b_duty;
      end
      if (b_ps === 1'b1) begin
        if (last_ps >= 0) begin
          n_cmp++;
          if (c - last_ps != 7) begin
            n_err++; $display("FAIL short_period_start gap=%0d want 7", c - last_ps);
          end
        end
        last_ps = c;
      end
    end
    n_cmp++;
    if (nchg != 2 || chg_val[0] != 3 || chg_val[1] != 5 || chg_cyc[1] - chg_cyc[0] != 7) begin
      n_err++;
      $display("FAIL short_duty_seq changes=%0d v0=%0d v1=%0d gap=%0d want 2,3,5,7", nchg,
               chg_val[0], chg_val[1], chg_cyc[1] - chg_cyc[0]);
    end
    k = 0;
    while (b_ps !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    hi = int'(b_pwm);
    repeat (6) begin @(negedge clk); hi += int'(b_pwm); end
    n_cmp++;
    if (hi != 5) begin n_err++; $display("FAIL short_pwm_high high=%0d want 5", hi); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_invalid_codes();
    test_enable();
    test_random();
    test_short_period();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
